bus_arbiter: RTL and testbench

Request scheduler in front of the coherence bus FSM. Collects up to `CORES` concurrent L1 controller requests, picks one per bus transaction using writeback-first round-robin with age-based starvation override, and presents it on a single request channel. It keeps that channel locked until the bus reports completion. It replaces fixed lowest-ID priority with a bounded-wait policy.

---
 rtl/bus_arbiter_pkg.sv | 21 ++
 rtl/bus_arbiter_rr_select.sv | 31 +++
 rtl/bus_arbiter.sv | 131 +++++++++++++
 tb/tb_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared cache/bus types and sizes used by the bus request arbiter.
// The bus request encoding and line geometry are common to every L1 and the bus FSM.
package bus_arbiter_pkg;

    localparam int CPU_CORES      = 4;
    localparam int ADDR_BITS      = 32;
    localparam int OFFSET_BITS    = 6;
    localparam int CACHELINE_BITS = 512;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_t;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_select #(
    parameter int CORES = 4
) (
    input  logic [CORES-1:0]         req,
    input  logic [$clog2(CORES)-1:0] ptr,
    output logic [CORES-1:0]         gnt,
    output logic [$clog2(CORES)-1:0] idx,
    output logic                     any
);

    localparam int IDXW = $clog2(CORES);

    int scan;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        scan = 0;
        for (int k = 0; k < CORES; k++) begin
            scan = (int'(ptr) + k) % CORES;
            if (!any && req[scan]) begin
                any       = 1'b1;
                idx       = IDXW'(scan);
                gnt[scan] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Bus request arbiter: writeback-first round-robin with age-based starvation override,
// one outstanding transaction, payload latched until the bus reports completion.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int CORES        = CPU_CORES,
    parameter int LADDR_BITS   = ADDR_BITS - OFFSET_BITS,
    parameter int LINE_BITS    = CACHELINE_BITS,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CORES-1:0]              l1_req_valid,
    output logic [CORES-1:0]              l1_req_ready,
    input  logic [CORES*LADDR_BITS-1:0]   l1_req_addr,
    input  bus_req_t                      l1_req [CORES],
    input  logic [CORES*LINE_BITS-1:0]    l1_req_data,
    output logic                          bus_req_valid,
    input  logic                          bus_req_ready,
    output logic [LADDR_BITS-1:0]         bus_req_addr,
    output bus_req_t                      bus_req_type,
    output logic [LINE_BITS-1:0]          bus_req_data,
    output logic [$clog2(CORES)-1:0]      bus_req_cpu,
    input  logic                          bus_done
);

    localparam int IDXW = $clog2(CORES);
    localparam int AGEW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     ptr_q;
    logic [AGEW-1:0]     age_q [CORES];

    logic [CORES-1:0]    starved, wb;
    logic [CORES-1:0]    gnt_s, gnt_w, gnt_a, win_gnt;
    logic [IDXW-1:0]     idx_s, idx_w, idx_a, win_idx;
    logic                any_s, any_w, any_a;
    logic                grant;

    always_comb begin
        starved = '0;
        wb      = '0;
        for (int i = 0; i < CORES; i++) begin
            starved[i] = l1_req_valid[i] && (age_q[i] == AGEW'(STARVE_LIMIT));
            wb[i]      = l1_req_valid[i] && (l1_req[i] == BUS_WB);
        end
    end

    rr_select #(.CORES(CORES)) u_sel_starved (.req(starved),      .ptr(ptr_q), .gnt(gnt_s), .idx(idx_s), .any(any_s));
    rr_select #(.CORES(CORES)) u_sel_wb      (.req(wb),           .ptr(ptr_q), .gnt(gnt_w), .idx(idx_w), .any(any_w));
    rr_select #(.CORES(CORES)) u_sel_all     (.req(l1_req_valid), .ptr(ptr_q), .gnt(gnt_a), .idx(idx_a), .any(any_a));

    // Starved beats writeback beats plain round-robin; the last class is the union of all.
    always_comb begin
        win_gnt = gnt_a;
        win_idx = idx_a;
        if (any_s) begin
            win_gnt = gnt_s;
            win_idx = idx_s;
        end else if (any_w) begin
            win_gnt = gnt_w;
            win_idx = idx_w;
        end
    end

    assign grant        = (state_q == IDLE) && any_a;
    assign l1_req_ready = grant ? win_gnt : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_a)         state_d = ISSUE;
            ISSUE:   if (bus_req_ready) state_d = WAIT;
            WAIT:    if (bus_done)      state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            bus_req_valid <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_type  <= BUS_RD;
            bus_req_data  <= '0;
            bus_req_cpu   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                bus_req_valid <= 1'b1;
                bus_req_addr  <= l1_req_addr[int'(win_idx)*LADDR_BITS +: LADDR_BITS];
                bus_req_type  <= l1_req[win_idx];
                bus_req_data  <= l1_req_data[int'(win_idx)*LINE_BITS +: LINE_BITS];
                bus_req_cpu   <= win_idx;
            end else if (state_q == ISSUE && bus_req_ready) begin
                bus_req_valid <= 1'b0;
            end
            if (state_q == WAIT && bus_done) begin
                ptr_q <= IDXW'(wrap_inc(int'(bus_req_cpu), CORES));
            end
        end
    end

    // A waiting core ages once per foreign grant; dropping valid forfeits accumulated age.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CORES; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (!l1_req_valid[i]) begin
                    age_q[i] <= '0;
                end else if (grant) begin
                    if (win_idx == IDXW'(i))
                        age_q[i] <= '0;
                    else if (age_q[i] != AGEW'(STARVE_LIMIT))
                        age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && bus_done)
            assert (state_q == WAIT)
            else $warning("bus_done seen outside WAIT, ignored");
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle reference model plus directed grant-order checks.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NC    = 4;
    localparam int LA    = ADDR_BITS - OFFSET_BITS;
    localparam int LB    = CACHELINE_BITS;
    localparam int LIMIT = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NC-1:0]        l1_req_valid = '0;
    logic [NC-1:0]        l1_req_ready;
    logic [NC*LA-1:0]     l1_req_addr = '0;
    bus_req_t             l1_req [NC];
    logic [NC*LB-1:0]     l1_req_data = '0;
    logic                 bus_req_valid;
    logic                 bus_req_ready = 1'b0;
    logic [LA-1:0]        bus_req_addr;
    bus_req_t             bus_req_type;
    logic [LB-1:0]        bus_req_data;
    logic [1:0]           bus_req_cpu;
    logic                 bus_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int dut_log[$];

    bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .l1_req_valid(l1_req_valid), .l1_req_ready(l1_req_ready),
        .l1_req_addr(l1_req_addr), .l1_req(l1_req), .l1_req_data(l1_req_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_type(bus_req_type),
        .bus_req_data(bus_req_data), .bus_req_cpu(bus_req_cpu),
        .bus_done(bus_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: phase 0 = free, 1 = presenting, 2 = accepted awaiting completion.
    int       m_phase, m_ptr, m_cpu;
    int       m_age [NC];
    logic [LA-1:0] m_addr;
    bus_req_t m_type;
    logic [LB-1:0] m_data;

    // Lowest (class rank, distance from ptr) wins; rank 0 starved, 1 writeback, 2 other.
    function automatic int pick();
        int best = -1;
        int best_key = 1000;
        for (int i = 0; i < NC; i++) begin
            if (l1_req_valid[i]) begin
                int rank = (m_age[i] == LIMIT) ? 0 : ((l1_req[i] == BUS_WB) ? 1 : 2);
                int key  = rank * NC + (i - m_ptr + NC) % NC;
                if (key < best_key) begin
                    best_key = key;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            m_phase = 0; m_ptr = 0; m_cpu = 0;
            m_addr = '0; m_type = BUS_RD; m_data = '0;
            for (int i = 0; i < NC; i++) m_age[i] = 0;
            chk("rst_ready", LB'(l1_req_ready), '0);
            chk("rst_valid", LB'(bus_req_valid), '0);
            chk("rst_addr",  LB'(bus_req_addr), '0);
            chk("rst_type",  LB'(bus_req_type), '0);
            chk("rst_data",  bus_req_data, '0);
            chk("rst_cpu",   LB'(bus_req_cpu), '0);
        end else begin
            int w;
            logic [NC-1:0] exp_ready;
            w = (m_phase == 0) ? pick() : -1;
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("model_ready", LB'(l1_req_ready), LB'(exp_ready));
            chk("model_valid", LB'(bus_req_valid), LB'(m_phase == 1));
            chk("model_addr",  LB'(bus_req_addr), LB'(m_addr));
            chk("model_type",  LB'(bus_req_type), LB'(m_type));
            chk("model_data",  bus_req_data, m_data);
            chk("model_cpu",   LB'(bus_req_cpu), LB'(m_cpu));
            for (int i = 0; i < NC; i++) if (l1_req_ready[i]) dut_log.push_back(i);
            if (w >= 0) begin
                m_addr = l1_req_addr[w*LA +: LA];
                m_type = l1_req[w];
                m_data = l1_req_data[w*LB +: LB];
                m_cpu  = w;
            end
            for (int i = 0; i < NC; i++) begin
                if (!l1_req_valid[i])   m_age[i] = 0;
                else if (i == w)        m_age[i] = 0;
                else if (w >= 0)        m_age[i] = (m_age[i] + 1 > LIMIT) ? LIMIT : m_age[i] + 1;
            end
            case (m_phase)
                0: if (w >= 0) m_phase = 1;
                1: if (bus_req_ready) m_phase = 2;
                2: if (bus_done) begin m_ptr = (m_cpu + 1) % NC; m_phase = 0; end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic set_req(input int c, input bus_req_t t, input logic [LA-1:0] a);
        l1_req_valid[c] = 1'b1;
        l1_req[c] = t;
        l1_req_addr[c*LA +: LA] = a;
        l1_req_data[c*LB +: LB] = {16{8'(c), 24'(a)}};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        l1_req_valid = '0;
        bus_req_ready = 1'b0;
        bus_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        dut_log.delete();
    endtask

    // One bus transaction: accept, one idle cycle, completion pulse. drop=1 models an L1
    // that withdraws its request once granted.
    task automatic serve(input bit drop);
        int t = 0;
        while (!bus_req_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("serve_timeout", LB'(t < 50), LB'(1));
        if (drop) l1_req_valid[bus_req_cpu] = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); #1 bus_req_ready = 1'b0;
        @(posedge clk); #1 bus_done = 1'b1;
        @(posedge clk); #1 bus_done = 1'b0;
    endtask

    task automatic expect_log(input string name, input int exp[$]);
        chk({name, "_count"}, LB'(dut_log.size()), LB'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_log.size(); i++)
            chk($sformatf("%s_%0d", name, i), LB'(dut_log[i]), LB'(exp[i]));
        dut_log.delete();
    endtask

    initial begin
        for (int i = 0; i < NC; i++) l1_req[i] = BUS_RD;

        // Basic handshake
        do_reset();
        @(posedge clk); #1 set_req(2, BUS_RD, LA'(26'h1A));
        #1 chk("basic_ready", LB'(l1_req_ready), LB'(4'b0100));
        @(posedge clk); #1;
        chk("basic_valid", LB'(bus_req_valid), LB'(1));
        chk("basic_addr",  LB'(bus_req_addr), LB'(26'h1A));
        chk("basic_cpu",   LB'(bus_req_cpu), LB'(2));
        serve(1'b1);
        chk("basic_ptr", LB'(dut.ptr_q), LB'(3));
        expect_log("basic", '{2});

        // Round-robin rotation with all cores continuously requesting
        do_reset();
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) set_req(c, BUS_RD, LA'(26'h100 + c));
        repeat (5) serve(1'b0);
        l1_req_valid = '0;
        repeat (3) @(posedge clk);
        expect_log("rr", '{0, 1, 2, 3, 0});

        // Writeback priority
        do_reset();
        @(posedge clk); #1;
        set_req(0, BUS_RD, LA'(26'h200));
        set_req(1, BUS_RD, LA'(26'h201));
        set_req(3, BUS_WB, LA'(26'h203));
        repeat (3) serve(1'b1);
        repeat (3) @(posedge clk);
        expect_log("wb", '{3, 0, 1});

        // Starvation override: core 1 wins after exactly 8 foreign grants
        do_reset();
        @(posedge clk); #1;
        set_req(0, BUS_WB, LA'(26'h300));
        set_req(1, BUS_RD, LA'(26'h301));
        set_req(2, BUS_WB, LA'(26'h302));
        set_req(3, BUS_WB, LA'(26'h303));
        repeat (9) serve(1'b0);
        l1_req_valid = '0;
        repeat (3) @(posedge clk);
        expect_log("starve", '{0, 2, 3, 0, 2, 3, 0, 2, 1});

        // Reset in WAIT: outputs clear at once and ptr restarts at 0
        do_reset();
        @(posedge clk); #1 set_req(2, BUS_RD, LA'(26'h400));
        serve(1'b1);
        set_req(3, BUS_RD, LA'(26'h403));
        @(posedge clk); #1;
        l1_req_valid[3] = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); #1 bus_req_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rstw_valid", LB'(bus_req_valid), '0);
        chk("rstw_addr",  LB'(bus_req_addr), '0);
        chk("rstw_cpu",   LB'(bus_req_cpu), '0);
        chk("rstw_data",  bus_req_data, '0);
        @(posedge clk); #1 reset_n = 1'b1;
        dut_log.delete();
        set_req(1, BUS_RD, LA'(26'h411));
        set_req(3, BUS_RD, LA'(26'h413));
        repeat (2) serve(1'b1);
        repeat (3) @(posedge clk);
        expect_log("rstw", '{1, 3});

        // Early bus_done in ISSUE is ignored
        do_reset();
        @(posedge clk); #1 set_req(0, BUS_RDX, LA'(26'h500));
        @(posedge clk); #1;
        l1_req_valid[0] = 1'b0;
        bus_done = 1'b1;
        @(posedge clk); #1 bus_done = 1'b0;
        chk("early_valid", LB'(bus_req_valid), LB'(1));
        chk("early_type",  LB'(bus_req_type), LB'(BUS_RDX));
        serve(1'b1);
        chk("early_ptr", LB'(dut.ptr_q), LB'(1));
        expect_log("early", '{0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
